rob_param: RTL and testbench

Parametrised reorder buffer: the successor of the fixed 16-entry ROB. It buffers issued instructions in program order, accepts results from two broadcast buses (ALU CDB and data-cache CDB), and serves operand lookups with same-cycle bypass. It commits one ready head entry per cycle to the register file or LSB, and flushes itself on a branch misprediction. It sits between Issue, the RS/LSB/REG blocks and the IFetcher.

---
 rtl/rob_param.sv | 177 +++++++++++++++++
 tb/tb_rob_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order issue, two CDB write-back ports,
// bypassed operand lookup, single in-order commit and misprediction flush.
module rob_param #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             is_valid,
  input  logic             is_ready,
  input  logic [2:0]       is_kind,
  input  logic [XLEN-1:0]  is_value,
  input  logic [4:0]       is_dest,
  input  logic             is_pred_taken,
  input  logic [XLEN-1:0]  is_alt_pc,
  output logic [TAG_W-1:0] is_tag,
  output logic             full,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [XLEN-1:0]  cdb0_value,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [XLEN-1:0]  cdb1_value,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [XLEN-1:0]  q1_value,
  output logic [XLEN-1:0]  q2_value,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [4:0]       commit_dest,
  output logic [XLEN-1:0]  commit_value,
  output logic             commit_we,
  output logic             commit_store,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc
);

  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_LOAD   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [TAG_W:0] COUNT_FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic             ready_q [DEPTH];
  logic [2:0]       kind_q  [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic [4:0]       dest_q  [DEPTH];
  logic             pred_q  [DEPTH];
  logic [XLEN-1:0]  alt_q   [DEPTH];

  logic live [DEPTH];
  logic issue_ok;
  logic do_commit;
  logic mispredict;
  logic [2:0] head_kind;

  assign full   = (count == COUNT_FULL);
  assign is_tag = tail;

  assign head_kind  = kind_q[head];
  assign issue_ok   = is_valid && !full;
  assign do_commit  = (count != '0) && ready_q[head];
  assign mispredict = do_commit && (head_kind == KIND_BRANCH) &&
                      (value_q[head][0] != pred_q[head]);

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = {1'b0, TAG_W'(i) - head} < count;
    end
  end

  // Operand lookup: a broadcast this cycle overrides the stored entry, cdb1 first.
  always_comb begin
    q1_ready = ready_q[q1_tag];
    q1_value = value_q[q1_tag];
    q2_ready = ready_q[q2_tag];
    q2_value = value_q[q2_tag];
    if (cdb1_valid && cdb1_tag == q1_tag) begin
      q1_ready = 1'b1;
      q1_value = cdb1_value;
    end else if (cdb0_valid && cdb0_tag == q1_tag) begin
      q1_ready = 1'b1;
      q1_value = cdb0_value;
    end
    if (cdb1_valid && cdb1_tag == q2_tag) begin
      q2_ready = 1'b1;
      q2_value = cdb1_value;
    end else if (cdb0_valid && cdb0_tag == q2_tag) begin
      q2_ready = 1'b1;
      q2_value = cdb0_value;
    end
  end

  // Queue state, entry storage and the registered commit/flush outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_dest  <= '0;
      commit_value <= '0;
      commit_we    <= 1'b0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ready_q[i] <= 1'b0;
        kind_q[i]  <= '0;
        value_q[i] <= '0;
        dest_q[i]  <= '0;
        pred_q[i]  <= 1'b0;
        alt_q[i]   <= '0;
      end
    end else if (rdy) begin
      commit_valid <= 1'b0;
      flush        <= 1'b0;
      if (do_commit) begin
        commit_valid <= 1'b1;
        commit_tag   <= head;
        commit_dest  <= dest_q[head];
        commit_value <= value_q[head];
        commit_we    <= (head_kind != KIND_BRANCH) && (head_kind != KIND_STORE);
        commit_store <= (head_kind == KIND_STORE);
      end
      if (mispredict) begin
        flush    <= 1'b1;
        flush_pc <= alt_q[head];
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ready_q[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (live[i] && !ready_q[i]) begin
            if (cdb1_valid && cdb1_tag == TAG_W'(i)) begin
              ready_q[i] <= 1'b1;
              value_q[i] <= cdb1_value;
            end else if (cdb0_valid && cdb0_tag == TAG_W'(i)) begin
              ready_q[i] <= 1'b1;
              value_q[i] <= cdb0_value;
            end
          end
        end
        if (issue_ok) begin
          ready_q[tail] <= is_ready;
          kind_q[tail]  <= is_kind;
          value_q[tail] <= is_value;
          dest_q[tail]  <= is_dest;
          pred_q[tail]  <= is_pred_taken;
          alt_q[tail]   <= is_alt_pc;
          tail          <= tail + 1'b1;
        end
        if (do_commit) begin
          head <= head + 1'b1;
        end
        count <= count + (TAG_W+1)'(issue_ok) - (TAG_W+1)'(do_commit);
      end
    end
  end

  // KIND_LOAD is named for readability; loads retire through the register path.
  logic unused_kind;
  assign unused_kind = ^KIND_LOAD;

endmodule

// File: tb/tb_rob_param.sv
// Directed testbench for rob_param: one task per scenario, inline checks.
module tb_rob_param;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             is_valid;
  logic             is_ready;
  logic [2:0]       is_kind;
  logic [XLEN-1:0]  is_value;
  logic [4:0]       is_dest;
  logic             is_pred_taken;
  logic [XLEN-1:0]  is_alt_pc;
  logic [TAG_W-1:0] is_tag;
  logic             full;
  logic             cdb0_valid;
  logic [TAG_W-1:0] cdb0_tag;
  logic [XLEN-1:0]  cdb0_value;
  logic             cdb1_valid;
  logic [TAG_W-1:0] cdb1_tag;
  logic [XLEN-1:0]  cdb1_value;
  logic [TAG_W-1:0] q1_tag;
  logic [TAG_W-1:0] q2_tag;
  logic             q1_ready;
  logic             q2_ready;
  logic [XLEN-1:0]  q1_value;
  logic [XLEN-1:0]  q2_value;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic [4:0]       commit_dest;
  logic [XLEN-1:0]  commit_value;
  logic             commit_we;
  logic             commit_store;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;

  int tests = 0;
  int fails = 0;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_valid(is_valid), .is_ready(is_ready), .is_kind(is_kind),
    .is_value(is_value), .is_dest(is_dest), .is_pred_taken(is_pred_taken),
    .is_alt_pc(is_alt_pc), .is_tag(is_tag), .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_we(commit_we), .commit_store(commit_store),
    .flush(flush), .flush_pc(flush_pc)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; is_valid = 1'b0; is_ready = 1'b0; is_kind = 3'd0;
    is_value = '0; is_dest = '0; is_pred_taken = 1'b0; is_alt_pc = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_value = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_value = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic drive_issue(input logic [2:0] kind, input logic rd,
                             input logic [XLEN-1:0] val, input logic [4:0] dest,
                             input logic pred, input logic [XLEN-1:0] alt);
    is_valid = 1'b1; is_kind = kind; is_ready = rd; is_value = val;
    is_dest = dest; is_pred_taken = pred; is_alt_pc = alt;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_commit_valid got %b want 0", commit_valid); end
    tests++; if (flush !== 1'b0) begin fails++; $display("[TB] FAIL reset_flush got %b want 0", flush); end
    tests++; if (flush_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_flush_pc got %h want 0", flush_pc); end
    tests++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full got %b want 0", full); end
    tests++; if (is_tag !== 4'd0) begin fails++; $display("[TB] FAIL reset_is_tag got %0d want 0", is_tag); end
    tests++; if (q1_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_q1_ready got %b want 0", q1_ready); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_ready_issue();
    logic [XLEN-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    apply_reset();
    drive_issue(3'd0, 1'b1, vals[0], 5'd1, 1'b0, '0);
    step();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("[TB] FAIL ri_early_commit got %b want 0", commit_valid); end
    tests++; if (is_tag !== 4'd1) begin fails++; $display("[TB] FAIL ri_is_tag got %0d want 1", is_tag); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive_issue(3'd0, 1'b1, vals[i+1], 5'(i+2), 1'b0, '0);
      else is_valid = 1'b0;
      step();
      tests++; if (commit_valid !== 1'b1) begin fails++; $display("[TB] FAIL ri_valid%0d got %b want 1", i, commit_valid); end
      tests++; if (commit_tag !== 4'(i)) begin fails++; $display("[TB] FAIL ri_tag%0d got %0d want %0d", i, commit_tag, i); end
      tests++; if (commit_value !== vals[i]) begin fails++; $display("[TB] FAIL ri_value%0d got %h want %h", i, commit_value, vals[i]); end
      tests++; if (commit_we !== 1'b1) begin fails++; $display("[TB] FAIL ri_we%0d got %b want 1", i, commit_we); end
    end
    step();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("[TB] FAIL ri_pulse_end got %b want 0", commit_valid); end
  endtask

  task automatic test_fill_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_issue(3'd0, 1'b0, 32'(i), 5'd3, 1'b0, '0);
      step();
    end
    tests++; if (full !== 1'b1) begin fails++; $display("[TB] FAIL ff_full got %b want 1", full); end
    tests++; if (is_tag !== 4'd0) begin fails++; $display("[TB] FAIL ff_wrap_tag got %0d want 0", is_tag); end
    drive_issue(3'd0, 1'b1, 32'h99, 5'd4, 1'b0, '0);
    step();
    is_valid = 1'b0;
    q1_tag = 4'd0; q2_tag = 4'd3;
    #1;
    tests++; if (q1_ready !== 1'b0) begin fails++; $display("[TB] FAIL ff_ignored_issue ready got %b want 0", q1_ready); end
    tests++; if (q2_value !== 32'h3) begin fails++; $display("[TB] FAIL ff_q2_value got %h want 3", q2_value); end
    tests++; if (is_tag !== 4'd0) begin fails++; $display("[TB] FAIL ff_tail_held got %0d want 0", is_tag); end
    cdb0_valid = 1'b1; cdb0_tag = 4'd0; cdb0_value = 32'h55;
    #1;
    tests++; if (q1_ready !== 1'b1 || q1_value !== 32'h55) begin fails++; $display("[TB] FAIL ff_bypass got %b/%h want 1/55", q1_ready, q1_value); end
    step();
    cdb0_valid = 1'b0;
    step();
    tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'd0) begin fails++; $display("[TB] FAIL ff_commit0 got %b/%0d want 1/0", commit_valid, commit_tag); end
    tests++; if (commit_value !== 32'h55) begin fails++; $display("[TB] FAIL ff_commit_value got %h want 55", commit_value); end
    tests++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL ff_full_drop got %b want 0", full); end
    drive_issue(3'd0, 1'b1, 32'h66, 5'd5, 1'b0, '0);
    step();
    is_valid = 1'b0;
    tests++; if (full !== 1'b1 || is_tag !== 4'd1) begin fails++; $display("[TB] FAIL ff_reuse got full=%b tag=%0d want 1/1", full, is_tag); end
    q1_tag = 4'd0;
    #1;
    tests++; if (q1_ready !== 1'b1 || q1_value !== 32'h66) begin fails++; $display("[TB] FAIL ff_reuse_entry got %b/%h want 1/66", q1_ready, q1_value); end
  endtask

  task automatic test_dual_cdb();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_issue(3'd0, 1'b0, '0, 5'd6, 1'b0, '0);
      step();
    end
    is_valid = 1'b0;
    cdb0_valid = 1'b1; cdb0_tag = 4'd5; cdb0_value = 32'hA;
    cdb1_valid = 1'b1; cdb1_tag = 4'd5; cdb1_value = 32'hB;
    q1_tag = 4'd5; q2_tag = 4'd4;
    #1;
    tests++; if (q1_ready !== 1'b1 || q1_value !== 32'hB) begin fails++; $display("[TB] FAIL dc_bypass got %b/%h want 1/b", q1_ready, q1_value); end
    step();
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    #1;
    tests++; if (q1_ready !== 1'b1 || q1_value !== 32'hB) begin fails++; $display("[TB] FAIL dc_stored got %b/%h want 1/b", q1_ready, q1_value); end
    tests++; if (q2_ready !== 1'b0) begin fails++; $display("[TB] FAIL dc_other_entry got %b want 0", q2_ready); end
    cdb0_valid = 1'b1; cdb0_tag = 4'd9; cdb0_value = 32'hC;
    step();
    cdb0_valid = 1'b0; q2_tag = 4'd9;
    #1;
    tests++; if (q2_ready !== 1'b0) begin fails++; $display("[TB] FAIL dc_nonlive got %b want 0", q2_ready); end
  endtask

  task automatic test_branch_flush();
    apply_reset();
    drive_issue(3'd1, 1'b0, '0, 5'd0, 1'b1, 32'h1000);
    step();
    drive_issue(3'd0, 1'b1, 32'h77, 5'd8, 1'b0, '0);
    step();
    drive_issue(3'd0, 1'b1, 32'h78, 5'd9, 1'b0, '0);
    step();
    is_valid = 1'b0;
    cdb0_valid = 1'b1; cdb0_tag = 4'd0; cdb0_value = 32'h0;
    step();
    cdb0_valid = 1'b0;
    drive_issue(3'd0, 1'b1, 32'hEE, 5'd10, 1'b0, '0);
    step();
    is_valid = 1'b0;
    tests++; if (flush !== 1'b1) begin fails++; $display("[TB] FAIL bf_flush got %b want 1", flush); end
    tests++; if (flush_pc !== 32'h1000) begin fails++; $display("[TB] FAIL bf_flush_pc got %h want 1000", flush_pc); end
    tests++; if (commit_valid !== 1'b1 || commit_we !== 1'b0) begin fails++; $display("[TB] FAIL bf_commit got %b/%b want 1/0", commit_valid, commit_we); end
    tests++; if (is_tag !== 4'd0) begin fails++; $display("[TB] FAIL bf_issue_discarded got %0d want 0", is_tag); end
    q1_tag = 4'd1;
    #1;
    tests++; if (q1_ready !== 1'b0) begin fails++; $display("[TB] FAIL bf_ready_cleared got %b want 0", q1_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin fails++; $display("[TB] FAIL bf_quiet%0d got %b/%b want 0/0", i, commit_valid, flush); end
    end
  endtask

  task automatic test_store_load();
    apply_reset();
    drive_issue(3'd3, 1'b0, '0, 5'd0, 1'b0, '0);
    step();
    drive_issue(3'd2, 1'b0, '0, 5'd7, 1'b0, '0);
    step();
    is_valid = 1'b0;
    cdb1_valid = 1'b1; cdb1_tag = 4'd0; cdb1_value = 32'h5;
    cdb0_valid = 1'b1; cdb0_tag = 4'd1; cdb0_value = 32'h9;
    step();
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    step();
    tests++; if (commit_valid !== 1'b1 || commit_store !== 1'b1 || commit_we !== 1'b0) begin fails++; $display("[TB] FAIL sl_store got v=%b st=%b we=%b want 1/1/0", commit_valid, commit_store, commit_we); end
    step();
    tests++; if (commit_valid !== 1'b1 || commit_store !== 1'b0 || commit_we !== 1'b1) begin fails++; $display("[TB] FAIL sl_load got v=%b st=%b we=%b want 1/0/1", commit_valid, commit_store, commit_we); end
    tests++; if (commit_value !== 32'h9 || commit_dest !== 5'd7) begin fails++; $display("[TB] FAIL sl_load_data got %h/%0d want 9/7", commit_value, commit_dest); end
  endtask

  task automatic test_stall();
    apply_reset();
    rdy = 1'b0;
    drive_issue(3'd0, 1'b1, 32'h44, 5'd2, 1'b0, '0);
    step();
    tests++; if (is_tag !== 4'd0) begin fails++; $display("[TB] FAIL st_hold got %0d want 0", is_tag); end
    rdy = 1'b1;
    step();
    is_valid = 1'b0;
    tests++; if (is_tag !== 4'd1) begin fails++; $display("[TB] FAIL st_resume got %0d want 1", is_tag); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_issue(3'd0, 1'b0, '0, 5'd11, 1'b0, '0);
      step();
    end
    is_valid = 1'b0;
    cdb0_valid = 1'b1; cdb0_tag = 4'd0; cdb0_value = 32'h42;
    step();
    cdb0_valid = 1'b0;
    step();
    tests++; if (commit_valid !== 1'b1 || commit_value !== 32'h42) begin fails++; $display("[TB] FAIL ar_pre got %b/%h want 1/42", commit_valid, commit_value); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (commit_valid !== 1'b0 || commit_value !== 32'h0) begin fails++; $display("[TB] FAIL ar_outputs got %b/%h want 0/0", commit_valid, commit_value); end
    tests++; if (is_tag !== 4'd0 || full !== 1'b0) begin fails++; $display("[TB] FAIL ar_tag got %0d/%b want 0/0", is_tag, full); end
    step();
    rst = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_ready_issue();
    test_fill_full();
    test_dual_cdb();
    test_branch_flush();
    test_store_load();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
